// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one combinational ALU: valid/ready request arbitration, a one-entry
// issue register driving the ALU, and a per-port response register with backpressure.
module alu_share_arbiter #(
  parameter int unsigned RR_MODE    = 1,  // 1: round-robin, 0: fixed priority + starvation guard
  parameter int unsigned STARVE_MAX = 8   // fixed-priority only: port 1 wait limit (1..255)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [9:0]  req_shamt,
  input  logic [7:0]  req_alufn,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [63:0] rsp_out,
  output logic [1:0]  rsp_cf,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_alufn,
  input  logic [31:0] alu_out,
  input  logic        alu_cf,
  output logic        busy
);

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  logic [1:0]  pending_q, pending_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic        iss_vld_q, iss_vld_d;
  logic        iss_port_q, iss_port_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [4:0]  alu_shamt_q, alu_shamt_d;
  logic [3:0]  alu_alufn_q, alu_alufn_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_out_q, rsp_out_d;
  logic [1:0]  rsp_cf_q, rsp_cf_d;

  logic [1:0]  rsp_hs;
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        gnt_port;

  // Eligibility and single-winner grant; a port whose result leaves this cycle may re-issue.
  always_comb begin
    rsp_hs = rsp_valid_q & rsp_ready;
    // Gated by rst_n so req_ready stays low while reset is held.
    elig   = req_valid & (~pending_q | rsp_hs) & {2{rst_n}};
    grant  = elig;
    if (elig == 2'b11) begin
      if (RR_MODE != 0) begin
        grant = rr_ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant = (starve_cnt_q == StarveMax) ? 2'b10 : 2'b01;
      end
    end
    gnt_port = grant[1];
  end

  // Next-state for bookkeeping, issue register and response slots.
  always_comb begin
    pending_d = (pending_q & ~rsp_hs) | grant;

    rr_ptr_d = rr_ptr_q;
    if (|grant) rr_ptr_d = ~gnt_port;

    starve_cnt_d = starve_cnt_q;
    if (grant[1] || !req_valid[1]) begin
      starve_cnt_d = '0;
    end else if (elig[1] && (starve_cnt_q != 8'hFF)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    // Issue always retires next edge: the target response slot is free by construction.
    iss_vld_d   = |grant;
    iss_port_d  = iss_port_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_shamt_d = alu_shamt_q;
    alu_alufn_d = alu_alufn_q;
    if (|grant) begin
      iss_port_d  = gnt_port;
      alu_a_d     = gnt_port ? req_a[63:32]    : req_a[31:0];
      alu_b_d     = gnt_port ? req_b[63:32]    : req_b[31:0];
      alu_shamt_d = gnt_port ? req_shamt[9:5]  : req_shamt[4:0];
      alu_alufn_d = gnt_port ? req_alufn[7:4]  : req_alufn[3:0];
    end

    // A capture in the same edge as a handshake wins, keeping rsp_valid high.
    rsp_valid_d = rsp_valid_q & ~rsp_hs;
    rsp_out_d   = rsp_out_q;
    rsp_cf_d    = rsp_cf_q;
    if (iss_vld_q) begin
      if (iss_port_q) begin
        rsp_valid_d[1]   = 1'b1;
        rsp_out_d[63:32] = alu_out;
        rsp_cf_d[1]      = alu_cf;
      end else begin
        rsp_valid_d[0]   = 1'b1;
        rsp_out_d[31:0]  = alu_out;
        rsp_cf_d[0]      = alu_cf;
      end
    end
  end

  // State registers; reset discards any in-flight op and undelivered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      rr_ptr_q     <= 1'b0;
      starve_cnt_q <= '0;
      iss_vld_q    <= 1'b0;
      iss_port_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_shamt_q  <= '0;
      alu_alufn_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_out_q    <= '0;
      rsp_cf_q     <= '0;
    end else begin
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      iss_vld_q    <= iss_vld_d;
      iss_port_q   <= iss_port_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_shamt_q  <= alu_shamt_d;
      alu_alufn_q  <= alu_alufn_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_out_q    <= rsp_out_d;
      rsp_cf_q     <= rsp_cf_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_cf    = rsp_cf_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_shamt = alu_shamt_q;
  assign alu_alufn = alu_alufn_q;
  assign busy      = iss_vld_q | (|pending_q);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench: a round-robin instance and a fixed-priority instance driven side by side, each checked
// every cycle against a transaction-level model (per-port outstanding op with a due cycle).
module tb_alu_share_arbiter;

  localparam int FpStarve = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index k: 0 = round-robin instance, 1 = fixed-priority instance.
  logic [1:0]  req_valid [2];
  logic [1:0]  req_ready [2];
  logic [63:0] req_a     [2];
  logic [63:0] req_b     [2];
  logic [9:0]  req_shamt [2];
  logic [7:0]  req_alufn [2];
  logic [1:0]  rsp_valid [2];
  logic [1:0]  rsp_ready [2];
  logic [63:0] rsp_out   [2];
  logic [1:0]  rsp_cf    [2];
  logic [31:0] alu_a     [2];
  logic [31:0] alu_b     [2];
  logic [4:0]  alu_shamt [2];
  logic [3:0]  alu_alufn [2];
  logic [31:0] alu_out   [2];
  logic        alu_cf    [2];
  logic        busy      [2];

  // Bench ALU: 0 ADD, 1 SUB (cf = borrow), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLTU, else pass a.
  function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh, input logic [3:0] fn);
    logic [32:0] r;
    case (fn)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {(a < b), a - b};
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {1'b0, a << sh};
      4'd6:    r = {1'b0, a >> sh};
      4'd7:    r = {1'b0, 31'd0, (a < b)};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  assign {alu_cf[0], alu_out[0]} = alu_fn(alu_a[0], alu_b[0], alu_shamt[0], alu_alufn[0]);
  assign {alu_cf[1], alu_out[1]} = alu_fn(alu_a[1], alu_b[1], alu_shamt[1], alu_alufn[1]);

  alu_share_arbiter #(.RR_MODE(1), .STARVE_MAX(8)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_shamt(req_shamt[0]), .req_alufn(req_alufn[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_out(rsp_out[0]),
    .rsp_cf(rsp_cf[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_shamt(alu_shamt[0]),
    .alu_alufn(alu_alufn[0]), .alu_out(alu_out[0]), .alu_cf(alu_cf[0]), .busy(busy[0])
  );

  alu_share_arbiter #(.RR_MODE(0), .STARVE_MAX(FpStarve)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_shamt(req_shamt[1]), .req_alufn(req_alufn[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_out(rsp_out[1]),
    .rsp_cf(rsp_cf[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_shamt(alu_shamt[1]),
    .alu_alufn(alu_alufn[1]), .alu_out(alu_out[1]), .alu_cf(alu_cf[1]), .busy(busy[1])
  );

  // Model: each port holds at most one op, due (visible) two cycles after its grant.
  int          cyc;
  bit          m_pend     [2][2];
  int          m_due      [2][2];
  logic [31:0] m_cur_out  [2][2];
  logic [31:0] m_prev_out [2][2];
  logic        m_cur_cf   [2][2];
  logic        m_prev_cf  [2][2];
  logic [31:0] m_op_a     [2][2];
  logic [31:0] m_op_b     [2][2];
  logic [4:0]  m_op_sh    [2][2];
  logic [3:0]  m_op_fn    [2][2];
  int          m_last     [2];   // port granted most recently (round-robin favours the other)
  int          m_wait     [2];   // cycles port 1 has been eligible but refused
  logic [1:0]  m_grant    [2];

  // Samples taken at the compare point, used by the literal checks.
  logic [1:0]  s_ready [2];
  logic [1:0]  s_rv    [2];
  logic [63:0] s_out   [2];
  logic [1:0]  s_cf    [2];

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[k][i]     = 1'b0;
        m_due[k][i]      = 0;
        m_cur_out[k][i]  = '0;
        m_prev_out[k][i] = '0;
        m_cur_cf[k][i]   = 1'b0;
        m_prev_cf[k][i]  = 1'b0;
      end
      m_last[k]  = 1;
      m_wait[k]  = 0;
      m_grant[k] = '0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 time unit after rise.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [1:0]  hs;
      logic [1:0]  el;
      logic [1:0]  g;
      logic [32:0] r;
      s_ready[k] = req_ready[k];
      s_rv[k]    = rsp_valid[k];
      s_out[k]   = rsp_out[k];
      s_cf[k]    = rsp_cf[k];
      for (int i = 0; i < 2; i++) begin
        hs[i] = m_pend[k][i] && (cyc >= m_due[k][i]) && rsp_ready[k][i];
        el[i] = rst_n && req_valid[k][i] && (!m_pend[k][i] || hs[i]);
      end
      if (el == 2'b11) begin
        if (k == 0) g = (m_last[k] == 0) ? 2'b10 : 2'b01;
        else        g = (m_wait[k] == FpStarve) ? 2'b10 : 2'b01;
      end else begin
        g = el;
      end
      check($sformatf("i%0d req_ready", k), req_ready[k], g);
      check($sformatf("i%0d busy", k), busy[k], m_pend[k][0] | m_pend[k][1]);
      for (int i = 0; i < 2; i++) begin
        logic shown;
        shown = cyc >= m_due[k][i];
        check($sformatf("i%0d p%0d rsp_valid", k, i), rsp_valid[k][i], m_pend[k][i] && shown);
        check($sformatf("i%0d p%0d rsp_out", k, i), rsp_out[k][32*i +: 32],
              shown ? m_cur_out[k][i] : m_prev_out[k][i]);
        check($sformatf("i%0d p%0d rsp_cf", k, i), rsp_cf[k][i],
              shown ? m_cur_cf[k][i] : m_prev_cf[k][i]);
        if (m_pend[k][i] && (cyc == m_due[k][i] - 1)) begin
          check($sformatf("i%0d p%0d alu_a", k, i), alu_a[k], m_op_a[k][i]);
          check($sformatf("i%0d p%0d alu_b", k, i), alu_b[k], m_op_b[k][i]);
          check($sformatf("i%0d p%0d alu_shamt", k, i), alu_shamt[k], m_op_sh[k][i]);
          check($sformatf("i%0d p%0d alu_alufn", k, i), alu_alufn[k], m_op_fn[k][i]);
        end
      end
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (g[i]) begin
            m_prev_out[k][i] = m_cur_out[k][i];
            m_prev_cf[k][i]  = m_cur_cf[k][i];
            m_op_a[k][i]     = req_a[k][32*i +: 32];
            m_op_b[k][i]     = req_b[k][32*i +: 32];
            m_op_sh[k][i]    = req_shamt[k][5*i +: 5];
            m_op_fn[k][i]    = req_alufn[k][4*i +: 4];
            r = alu_fn(m_op_a[k][i], m_op_b[k][i], m_op_sh[k][i], m_op_fn[k][i]);
            m_cur_out[k][i]  = r[31:0];
            m_cur_cf[k][i]   = r[32];
            m_due[k][i]      = cyc + 2;
            m_pend[k][i]     = 1'b1;
          end else if (hs[i]) begin
            m_pend[k][i] = 1'b0;
          end
        end
        if (g[0]) m_last[k] = 0;
        if (g[1]) m_last[k] = 1;
        if (g[1] || !req_valid[k][1]) m_wait[k] = 0;
        else if (el[1] && m_wait[k] < 255) m_wait[k]++;
      end
      m_grant[k] = g;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_op(input int k, input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [3:0] fn);
    req_a[k][32*i +: 32]    = a;
    req_b[k][32*i +: 32]    = b;
    req_shamt[k][5*i +: 5]  = sh;
    req_alufn[k][4*i +: 4]  = fn;
  endtask

  // Requests are held until granted; a fresh op (or idle) is chosen only after a grant.
  task automatic drive_random(input int vprob, input int rprob);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[k][i] || m_grant[k][i]) begin
          req_valid[k][i] = ($urandom_range(99) < vprob);
          set_op(k, i, ($urandom_range(3) == 0) ? 32'($urandom_range(7)) : $urandom(),
                 ($urandom_range(3) == 0) ? 32'($urandom_range(7)) : $urandom(),
                 5'($urandom_range(31)), 4'($urandom_range(9)));
        end
        rsp_ready[k][i] = ($urandom_range(99) < rprob);
      end
    end
  endtask

  task automatic single_op(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] fn, input logic [31:0] eo, input logic ecf,
                           input string nm);
    logic [1:0] m;
    m = 2'b01 << i;
    for (int k = 0; k < 2; k++) begin
      set_op(k, i, a, b, 5'd0, fn);
      req_valid[k] = m;
      rsp_ready[k] = 2'b11;
    end
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s i%0d accept", nm, k), s_ready[k], m);
      req_valid[k] = 2'b00;
    end
    step();
    for (int k = 0; k < 2; k++) check($sformatf("%s i%0d early", nm, k), s_rv[k][i], 1'b0);
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s i%0d valid", nm, k), s_rv[k][i], 1'b1);
      check($sformatf("%s i%0d out", nm, k), s_out[k][32*i +: 32], eo);
      check($sformatf("%s i%0d cf", nm, k), s_cf[k][i], ecf);
    end
  endtask

  initial begin
    int         p1cnt [2];
    logic [1:0] stale [2];
    cyc   = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 2'b11;  // held high during reset: ready must still be low
      rsp_ready[k] = 2'b11;
      req_a[k] = '0; req_b[k] = '0; req_shamt[k] = '0; req_alufn[k] = '0;
    end
    reset_model();
    #12;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset i%0d req_ready", k), req_ready[k], 2'b00);
      check($sformatf("reset i%0d rsp_valid", k), rsp_valid[k], 2'b00);
      check($sformatf("reset i%0d rsp_out", k), rsp_out[k], 64'd0);
      check($sformatf("reset i%0d busy", k), busy[k], 1'b0);
      check($sformatf("reset i%0d alu_a", k), alu_a[k], 32'd0);
      req_valid[k] = 2'b00;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both ports streaming: grants alternate 0,1,0,... from reset on both instances.
    for (int k = 0; k < 2; k++) begin
      set_op(k, 0, 32'd1, 32'd1, 5'd0, 4'd0);
      set_op(k, 1, 32'd7, 32'd2, 5'd0, 4'd1);
      req_valid[k] = 2'b11;
    end
    for (int c = 0; c < 6; c++) begin
      step();
      for (int k = 0; k < 2; k++)
        check($sformatf("alt i%0d grant%0d", k, c), s_ready[k], (c % 2 == 0) ? 2'b01 : 2'b10);
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("alt i%0d p0 result", k), s_out[k][31:0], 32'd2);
      check($sformatf("alt i%0d p1 result", k), s_out[k][63:32], 32'd5);
      req_valid[k] = 2'b00;
    end
    repeat (3) step();

    single_op(0, 32'd5, 32'd3, 4'd0, 32'd8, 1'b0, "add5+3");
    single_op(1, 32'd1, 32'd2, 4'd7, 32'd1, 1'b0, "sltu");
    single_op(0, 32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF, 1'b1, "sub0-1");
    single_op(1, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b1, "addcarry");

    // Port 0 backpressured: result held, no new port-0 grant, port 1 keeps flowing.
    for (int k = 0; k < 2; k++) begin
      set_op(k, 0, 32'd10, 32'd20, 5'd0, 4'd0);
      set_op(k, 1, 32'h0F0F, 32'h00FF, 5'd0, 4'd4);
      req_valid[k] = 2'b11;
      rsp_ready[k] = 2'b11;
      p1cnt[k] = 0;
    end
    repeat (3) step();
    for (int k = 0; k < 2; k++) rsp_ready[k] = 2'b10;
    repeat (2) step();
    repeat (5) begin
      step();
      for (int k = 0; k < 2; k++) begin
        check($sformatf("bp i%0d p0 ready", k), s_ready[k][0], 1'b0);
        check($sformatf("bp i%0d p0 valid", k), s_rv[k][0], 1'b1);
        check($sformatf("bp i%0d p0 held", k), s_out[k][31:0], 32'd30);
        p1cnt[k] += int'(s_ready[k][1]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("bp i%0d p1 grants>=2", k), p1cnt[k] >= 2, 1'b1);
      req_valid[k] = 2'b00;
      rsp_ready[k] = 2'b11;
    end
    repeat (3) step();

    // Randomised traffic under several valid/ready densities.
    for (int seg = 0; seg < 4; seg++) begin
      repeat (600) begin
        case (seg)
          0:       drive_random(80, 90);
          1:       drive_random(95, 30);
          2:       drive_random(50, 60);
          default: drive_random(100, 100);
        endcase
        step();
      end
    end

    // Reset with an op in the issue register and a port-1 result waiting.
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 2'b00;
      rsp_ready[k] = 2'b11;
    end
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      rsp_ready[k] = 2'b00;
      set_op(k, 1, 32'd9, 32'd4, 5'd0, 4'd1);
      req_valid[k] = 2'b10;
    end
    step();
    for (int k = 0; k < 2; k++) req_valid[k] = 2'b00;
    repeat (2) step();
    for (int k = 0; k < 2; k++) begin
      set_op(k, 0, 32'd3, 32'd3, 5'd0, 4'd0);
      req_valid[k] = 2'b01;
    end
    step();
    for (int k = 0; k < 2; k++) check($sformatf("pre-rst i%0d p1 valid", k), s_rv[k][1], 1'b1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mid-rst i%0d rsp_valid", k), rsp_valid[k], 2'b00);
      check($sformatf("mid-rst i%0d busy", k), busy[k], 1'b0);
      check($sformatf("mid-rst i%0d req_ready", k), req_ready[k], 2'b00);
      req_valid[k] = 2'b00;
    end
    reset_model();
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rsp_ready[k] = 2'b11;
      stale[k] = 2'b00;
    end
    repeat (4) begin
      step();
      for (int k = 0; k < 2; k++) stale[k] |= s_rv[k];
    end
    for (int k = 0; k < 2; k++) check($sformatf("post-rst i%0d stale", k), stale[k], 2'b00);

    repeat (200) begin
      drive_random(70, 70);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
